act_lut_engine: RTL and testbench



---
 rtl/act_lut_pkg.sv | 17 +
 rtl/act_lut_bsearch.sv | 44 ++++
 rtl/act_lut_engine.sv | 132 +++++++++++++
 tb/tb_act_lut_engine.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/act_lut_pkg.sv
// act_lut_pkg: shared encodings, FSM states and saturation helper for act_lut_engine
package act_lut_pkg;
   localparam logic [1:0] MODE_LUT  = 2'b00;
   localparam logic [1:0] MODE_RELU = 2'b01;
   localparam logic [1:0] MODE_ID   = 2'b10;
   localparam logic [1:0] WR_X      = 2'b00;
   localparam logic [1:0] WR_Y      = 2'b01;
   localparam logic [1:0] WR_S      = 2'b10;
   localparam logic [1:0] WR_NONE   = 2'b11;
   typedef enum logic [1:0] {IDLE, SEARCH, MULT, DONE} state_t;
   function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return v > hi ? hi : v < lo ? lo : v;
   endfunction
endpackage

// File: rtl/act_lut_bsearch.sv
// act_lut_bsearch: fixed-length binary search for the last breakpoint not above the key
module act_lut_bsearch #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] key,
   input  logic signed [DATA_W-1:0] x_first,
   input  logic signed [DATA_W-1:0] probe_x,
   output logic        [ADDR_W-1:0] probe_idx,
   output logic        [ADDR_W-1:0] idx,
   output logic                     below,
   output logic                     done
);
   logic signed [DATA_W-1:0] key_q;
   logic [ADDR_W-1:0] lo, step;
   logic busy, hit;
   assign probe_idx = lo | (ADDR_W'(1) << step);
   assign hit = probe_x <= key_q;
   assign idx = (busy && hit) ? probe_idx : lo;
   assign done = busy && step == '0;
   // one index bit resolved per cycle, MSB first; the last bit is visible combinationally on done
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_q <= '0;
         lo    <= '0;
         step  <= '0;
         below <= 1'b0;
         busy  <= 1'b0;
      end else if (start) begin
         key_q <= key;
         lo    <= '0;
         step  <= ADDR_W'(ADDR_W - 1);
         below <= key < x_first;
         busy  <= 1'b1;
      end else if (busy) begin
         lo    <= idx;
         step  <= step - ADDR_W'(1);
         busy  <= step != '0;
      end
   end
endmodule

// File: rtl/act_lut_engine.sv
// act_lut_engine: programmable piecewise activation (LUT/ReLU/identity); define ACT_LUT_INTERP_EN for slope interpolation
module act_lut_engine
   import act_lut_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int DEPTH  = 128,
   parameter logic signed [DATA_W-1:0] Y_MIN = '0,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               mode,
   input  logic                     wr_en,
   input  logic [1:0]               wr_sel,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     wr_err,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data
);
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FRAC_W >= DATA_W) begin : g_cfg_chk
      $error("act_lut_engine: DEPTH must be a power of two >= 2 and FRAC_W < DATA_W");
   end
   state_t state, nxt;
   logic signed [DATA_W-1:0] x_tab [DEPTH];
   logic signed [DATA_W-1:0] y_tab [DEPTH];
   logic signed [DATA_W-1:0] probe_x, y_i, lut_res, old_v, sh_old;
   logic [ADDR_W-1:0] probe_idx, idx, sh_addr;
   logic [1:0] sh_sel;
   logic sh_v, accept, below, bs_done, wr_ok, res_load;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign accept    = in_valid && in_ready;
   // a write colliding with acceptance is shadowed by its old value until the sample leaves
   assign probe_x = (sh_v && sh_sel == WR_X && sh_addr == probe_idx) ? sh_old : x_tab[probe_idx];
   assign y_i     = (sh_v && sh_sel == WR_Y && sh_addr == idx) ? sh_old : y_tab[idx];
`ifdef ACT_LUT_INTERP_EN
   localparam int PW = 2 * DATA_W + 1;
   localparam state_t POST_SEARCH = MULT;
   logic signed [DATA_W-1:0] s_tab [DEPTH];
   logic signed [DATA_W-1:0] key_q, x_i, s_i;
   logic signed [PW-1:0] acc;
   assign wr_ok    = wr_sel != WR_NONE;
   assign old_v    = wr_sel == WR_X ? x_tab[wr_addr] : wr_sel == WR_Y ? y_tab[wr_addr] : s_tab[wr_addr];
   assign x_i      = (sh_v && sh_sel == WR_X && sh_addr == idx) ? sh_old : x_tab[idx];
   assign s_i      = (sh_v && sh_sel == WR_S && sh_addr == idx) ? sh_old : s_tab[idx];
   assign acc      = (((PW'(key_q) - PW'(x_i)) * PW'(s_i)) >>> FRAC_W) + PW'(y_i);
   assign lut_res  = below ? Y_MIN : DATA_W'(sat_to(64'(acc), DATA_W));
   assign res_load = state == MULT;
   // slope table writes and the key kept for the interpolation step
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) s_tab[i] <= '0;
         key_q <= '0;
      end else begin
         if (wr_en && in_ready && wr_sel == WR_S) s_tab[wr_addr] <= wr_data;
         if (accept) key_q <= in_data;
      end
   end
`else
   localparam state_t POST_SEARCH = DONE;
   assign wr_ok    = wr_sel == WR_X || wr_sel == WR_Y;
   assign old_v    = wr_sel == WR_X ? x_tab[wr_addr] : y_tab[wr_addr];
   assign lut_res  = below ? Y_MIN : y_i;
   assign res_load = state == SEARCH && bs_done;
`endif
   act_lut_bsearch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bsearch (
      .clk       (clk),
      .reset     (reset),
      .start     (accept && mode == MODE_LUT),
      .key       (in_data),
      .x_first   (x_tab[0]),
      .probe_x   (probe_x),
      .probe_idx (probe_idx),
      .idx       (idx),
      .below     (below),
      .done      (bs_done)
   );
   // breakpoint and output table writes, taken only while idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            x_tab[i] <= '0;
            y_tab[i] <= '0;
         end
      end else if (wr_en && in_ready) begin
         if (wr_sel == WR_X) x_tab[wr_addr] <= wr_data;
         if (wr_sel == WR_Y) y_tab[wr_addr] <= wr_data;
      end
   end
   // next-state selection
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = in_valid ? (mode == MODE_LUT ? SEARCH : DONE) : IDLE;
         SEARCH:  nxt = bs_done ? POST_SEARCH : SEARCH;
         MULT:    nxt = DONE;
         DONE:    nxt = out_ready ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
   end
   // state, result register, dropped-write pulse and collision shadow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         out_data <= '0;
         wr_err   <= 1'b0;
         sh_v     <= 1'b0;
         sh_sel   <= '0;
         sh_addr  <= '0;
         sh_old   <= '0;
      end else begin
         state  <= nxt;
         wr_err <= wr_en && wr_ok && !in_ready;
         if (accept) begin
            sh_v    <= wr_en && wr_ok;
            sh_sel  <= wr_sel;
            sh_addr <= wr_addr;
            sh_old  <= old_v;
         end else if (out_valid && out_ready) begin
            sh_v    <= 1'b0;
         end
         if (accept && mode != MODE_LUT) out_data <= (mode == MODE_RELU && in_data[DATA_W-1]) ? '0 : in_data;
         else if (res_load) out_data <= lut_res;
      end
   end
endmodule

// File: tb/tb_act_lut_engine.sv
// tb_act_lut_engine: vector table, directed corner sequences and randomized model checks for act_lut_engine
`timescale 1ns/1ps
module tb_act_lut_engine;
   localparam int DEPTH = 8;
   localparam int AW = 3;
   localparam int FW = 8;
`ifdef ACT_LUT_INTERP_EN
   localparam int LL = AW + 2;
`else
   localparam int LL = AW + 1;
`endif
   logic clk = 0, reset = 0;
   logic [1:0] mode = 0, wr_sel = 0;
   logic wr_en = 0, in_valid = 0, out_ready = 0;
   logic [AW-1:0] wr_addr = 0;
   logic [15:0] wr_data = 0;
   logic signed [15:0] in_data = 0;
   logic wr_err, in_ready, out_valid;
   logic signed [15:0] out_data;
   int chk_cnt = 0, pass_cnt = 0;
   int mx[DEPTH], my[DEPTH], ms[DEPTH];

   typedef struct {
      string name;
      int md;
      logic [15:0] din;
      logic [15:0] exp;
      int lat;
   } vec_t;
   vec_t vecs[$];

   act_lut_engine #(.DATA_W(16), .FRAC_W(FW), .DEPTH(DEPTH), .Y_MIN(16'sh0000)) dut (
      .clk(clk), .reset(reset), .mode(mode), .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   // reference: linear scan from the top for the last breakpoint <= input
   function automatic int model(input int md, input int din);
      longint r;
      if (md == 1) return din < 0 ? 0 : din;
      if (md != 0) return din;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (mx[i] <= din) begin
            r = longint'(my[i]) + (((longint'(din) - mx[i]) * ms[i]) >>> FW);
            return r > 32767 ? 32767 : r < -32768 ? -32768 : int'(r);
         end
      end
      return 0;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      chk_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
   endtask

   task automatic wr(input int sel, input int a, input int d);
      wr_sel = 2'(sel); wr_addr = AW'(a); wr_data = 16'(d); wr_en = 1;
      @(posedge clk); #1;
      wr_en = 0;
      if (sel == 0) mx[a] = sx(16'(d));
      if (sel == 1) my[a] = sx(16'(d));
`ifdef ACT_LUT_INTERP_EN
      if (sel == 2) ms[a] = sx(16'(d));
`endif
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic finish_lookup(output int got, output int lat);
      wait_valid(lat);
      got = sx(out_data);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
   endtask

   // accept one sample, then scramble mode/data to show they are not re-sampled
   task automatic lookup(input int md, input int din, output int got, output int lat);
      mode = 2'(md); in_data = 16'(din); in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0; mode = 2'($urandom); in_data = 16'($urandom);
      finish_lookup(got, lat);
   endtask

   initial begin
      int got, lat, v, md, din, j;
      logic bp_ok;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", int'(out_valid), 0);
      check("reset in_ready", int'(in_ready), 1);
      check("reset out_data", sx(out_data), 0);
      check("reset wr_err", int'(wr_err), 0);
      @(negedge clk) reset = 1;
      @(posedge clk); #1;
      for (int i = 0; i < DEPTH; i++) begin
         wr(0, i, 16'hFA00 + i * 16'h0180);
         wr(1, i, i * 16'h0020);
      end

      vecs.push_back('{name:"lut_zero",   md:0, din:16'h0000, exp:16'h0080, lat:LL});
      vecs.push_back('{name:"lut_below",  md:0, din:16'hF000, exp:16'h0000, lat:LL});
      vecs.push_back('{name:"lut_max",    md:0, din:16'h7FFF, exp:16'h00E0, lat:LL});
      vecs.push_back('{name:"lut_exact",  md:0, din:16'hFE80, exp:16'h0060, lat:LL});
      vecs.push_back('{name:"lut_justlo", md:0, din:16'hFE7F, exp:16'h0040, lat:LL});
      vecs.push_back('{name:"lut_x0",     md:0, din:16'hFA00, exp:16'h0000, lat:LL});
      vecs.push_back('{name:"lut_x7",     md:0, din:16'h0480, exp:16'h00E0, lat:LL});
      vecs.push_back('{name:"lut_x7m1",   md:0, din:16'h047F, exp:16'h00C0, lat:LL});
      vecs.push_back('{name:"relu_neg",   md:1, din:16'hFF00, exp:16'h0000, lat:1});
      vecs.push_back('{name:"relu_pos",   md:1, din:16'h0123, exp:16'h0123, lat:1});
      vecs.push_back('{name:"ident",      md:2, din:16'h1234, exp:16'h1234, lat:1});
      vecs.push_back('{name:"ident_11",   md:3, din:16'h8000, exp:16'h8000, lat:1});
      foreach (vecs[i]) begin
         lookup(vecs[i].md, sx(vecs[i].din), got, lat);
         check({vecs[i].name, " data"}, got, sx(vecs[i].exp));
         check({vecs[i].name, " latency"}, lat, vecs[i].lat);
      end

      // backpressure with a dropped write in the middle
      mode = 0; in_data = 0; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      wait_valid(lat);
      check("bp latency", lat, LL);
      bp_ok = 1;
      for (int c = 0; c < 10; c++) begin
         if (c == 2) begin
            wr_en = 1; wr_sel = 2'b01; wr_addr = 3'd4; wr_data = 16'h7777;
         end
         @(posedge clk); #1;
         wr_en = 0;
         if (c == 2) check("busy write wr_err pulse", int'(wr_err), 1);
         if (c == 3) check("busy write wr_err single", int'(wr_err), 0);
         if (!(out_valid && out_data == 16'h0080 && !in_ready)) bp_ok = 0;
      end
      check("bp hold stable", int'(bp_ok), 1);
      out_ready = 1; in_valid = 1; in_data = 0; mode = 0;
      @(posedge clk); #1;
      out_ready = 0;
      check("bp release in_ready", int'(in_ready), 1);
      check("bp release out_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      in_valid = 0;
      check("bp next accepted", int'(in_ready), 0);
      finish_lookup(got, lat);
      check("bp readback unchanged", got, 16'h0080);
      check("bp readback latency", lat, LL);

      // write and acceptance in the same idle cycle: search sees the old entry
      mode = 0; in_data = 0; in_valid = 1;
      wr_en = 1; wr_sel = 2'b01; wr_addr = 3'd4; wr_data = 16'h5555;
      @(posedge clk); #1;
      in_valid = 0; wr_en = 0;
      finish_lookup(got, lat);
      check("collide pre-write", got, 16'h0080);
      my[4] = 16'h5555;
      lookup(0, 0, got, lat);
      check("collide post-write", got, 16'h5555);
      wr(1, 4, 16'h0080);

`ifdef ACT_LUT_INTERP_EN
      wr(2, 4, 16'h0080);
      lookup(0, 16'h0100, got, lat);
      check("interp data", got, 16'h0100);
      check("interp latency", lat, 5);
      lookup(0, sx(16'hF000), got, lat);
      check("interp below", got, 0);
      check("interp below latency", lat, 5);
`else
      mode = 0; in_data = 0; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      wr_en = 1; wr_sel = 2'b10; wr_addr = 3'd1; wr_data = 16'h1111;
      @(posedge clk); #1;
      wr_en = 0;
      check("slope write no wr_err", int'(wr_err), 0);
      finish_lookup(got, lat);
      check("slope write step result", got, 16'h0080);
`endif

      // randomized tables (sorted, duplicates allowed) and samples against the model
      v = -20000 + int'($urandom_range(0, 4000));
      for (int i = 0; i < DEPTH; i++) begin
         wr(0, i, v);
         wr(1, i, int'($urandom_range(0, 16'hFFFF)));
`ifdef ACT_LUT_INTERP_EN
         wr(2, i, int'($urandom_range(0, 16'h03FF)) - 16'h0200);
`endif
         v += ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6000));
      end
      for (int n = 0; n < 60; n++) begin
         j = int'($urandom_range(0, DEPTH - 1));
         case ($urandom_range(0, 5))
            4: md = 1;
            5: md = int'($urandom_range(2, 3));
            default: md = 0;
         endcase
         case ($urandom_range(0, 2))
            0: din = sx(16'($urandom));
            1: din = mx[j];
            default: din = sx(16'(mx[j] - 1));
         endcase
         lookup(md, din, got, lat);
         check($sformatf("rand%0d data md=%0d in=%0d", n, md, din), got, model(md, din));
         check($sformatf("rand%0d latency", n), lat, md == 0 ? LL : 1);
      end

      // asynchronous reset in the middle of a search
      mode = 0; in_data = 0; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); #3;
      check("busy before reset", int'(in_ready), 0);
      reset = 0;
      #1;
      check("async reset out_valid", int'(out_valid), 0);
      check("async reset in_ready", int'(in_ready), 1);
      @(negedge clk) reset = 1;
      for (int i = 0; i < DEPTH; i++) begin
         mx[i] = 0; my[i] = 0; ms[i] = 0;
      end
      lookup(0, 0, got, lat);
      check("after reset cleared", got, 0);
      check("after reset latency", lat, LL);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
